// File: rtl/sseg_scan_ctrl.sv
// Four-digit seven-segment scan controller: shadow/active digit registers,
// blanked time-multiplexed anodes, PWM brightness, per-digit blink.
//
// state | meaning
// IDLE  | scanning stopped, display dark, counters at 0
// BLANK | start of a digit slot, all anodes off (anti-ghosting)
// ON    | remainder of the slot, current digit driven when lit
module sseg_scan_ctrl #(
   parameter int DIV_W        = 15,
   parameter int BLANK_CYCLES = 256,
   parameter int BLINK_W      = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [1:0] wr_addr,
   input  logic [5:0] wr_data,
   input  logic       commit,
   input  logic [3:0] bright,
   input  logic [3:0] blink_en,
   output logic [3:0] an,
   output logic [6:0] sseg,
   output logic       dp,
   output logic       frame_tick
);

   typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

   localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYCLES - 1);
   localparam logic [5:0]       DIGIT_RST  = 6'b010000;

   state_t               state, state_nx;
   logic [DIV_W-1:0]     slot_cnt;
   logic [1:0]           digit;
   logic [BLINK_W-1:0]   frame_cnt;
   logic [5:0]           shadow [4];
   logic [5:0]           active [4];
   logic                 commit_pend;
   logic                 slot_end, frame_end, wr_fire, apply_commit, lit;
   logic [5:0]           cur;
   logic [6:0]           seg_dec;

   assign wr_ready     = ~commit_pend;
   assign wr_fire      = wr_valid & ~commit_pend;
   assign slot_end     = (state != IDLE) && (slot_cnt == '1);
   assign frame_end    = slot_end && (digit == 2'd3);
   // With the display stopped there is no frame boundary to wait for.
   assign apply_commit = commit_pend & (enable ? frame_end : 1'b1);
   assign cur          = active[digit];

   always_comb begin
      state_nx = state;
      if (!enable) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    state_nx = BLANK;
            BLANK:   if (slot_cnt == BLANK_LAST) state_nx = ON;
            ON:      if (slot_cnt == '1) state_nx = BLANK;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      lit = enable && (state == ON) && !cur[4] && (slot_cnt[3:0] <= bright)
            && !(blink_en[digit] && frame_cnt[BLINK_W-1]);
   end

   always_comb begin
      seg_dec = 7'h7F;
      case (cur[3:0])
         4'h0: seg_dec = 7'h40;
         4'h1: seg_dec = 7'h79;
         4'h2: seg_dec = 7'h24;
         4'h3: seg_dec = 7'h30;
         4'h4: seg_dec = 7'h19;
         4'h5: seg_dec = 7'h12;
         4'h6: seg_dec = 7'h02;
         4'h7: seg_dec = 7'h78;
         4'h8: seg_dec = 7'h00;
         4'h9: seg_dec = 7'h10;
         4'hA: seg_dec = 7'h08;
         4'hB: seg_dec = 7'h03;
         4'hC: seg_dec = 7'h46;
         4'hD: seg_dec = 7'h21;
         4'hE: seg_dec = 7'h06;
         4'hF: seg_dec = 7'h0E;
         default: seg_dec = 7'h7F;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         slot_cnt    <= '0;
         digit       <= 2'd0;
         frame_cnt   <= '0;
         commit_pend <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= DIGIT_RST;
            active[i] <= DIGIT_RST;
         end
         an          <= 4'hF;
         sseg        <= 7'h7F;
         dp          <= 1'b1;
         frame_tick  <= 1'b0;
      end else begin
         state <= state_nx;
         if (wr_fire) shadow[wr_addr] <= wr_data;
         if (commit && !commit_pend) commit_pend <= 1'b1;
         // Write and commit in one cycle: the write lands first, so the
         // copy (always at a later edge) picks it up.
         if (apply_commit) begin
            commit_pend <= 1'b0;
            for (int i = 0; i < 4; i++) active[i] <= shadow[i];
         end
         if (!enable) begin
            slot_cnt  <= '0;
            digit     <= 2'd0;
            frame_cnt <= '0;
         end else if (state != IDLE) begin
            slot_cnt <= slot_cnt + DIV_W'(1);
            if (slot_end)  digit     <= digit + 2'd1;
            if (frame_end) frame_cnt <= frame_cnt + BLINK_W'(1);
         end
         an         <= lit ? ~(4'b0001 << digit) : 4'hF;
         sseg       <= lit ? seg_dec : 7'h7F;
         dp         <= lit ? ~cur[5] : 1'b1;
         frame_tick <= enable & frame_end;
      end
   end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with a short slot (64 clks, 16 blank)
// so whole frames (256 clks) can be captured and inspected.
module tb_sseg_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset, enable, wr_valid, commit;
   logic       wr_ready, dp, frame_tick;
   logic [1:0] wr_addr;
   logic [5:0] wr_data;
   logic [3:0] bright, blink_en, an;
   logic [6:0] sseg;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

   logic [3:0] an_s   [1100];
   logic [6:0] sseg_s [1100];
   logic       dp_s   [1100];
   logic       ft_s   [1100];

   always #5 clk = ~clk;

   sseg_scan_ctrl #(.DIV_W(6), .BLANK_CYCLES(16), .BLINK_W(2)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .bright(bright), .blink_en(blink_en),
      .an(an), .sseg(sseg), .dp(dp), .frame_tick(frame_tick)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Steps until frame_tick is seen; returns cycles taken (bounded).
   task automatic wait_tick(output int cycles);
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (!frame_tick && cycles < 2000);
      if (!frame_tick) check_val("tick_timeout", 32'd0, 32'd1);
   endtask

   task automatic scan(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) begin
         step();
         an_s[k]   = an;
         sseg_s[k] = sseg;
         dp_s[k]   = dp;
         ft_s[k]   = frame_tick;
      end
   endtask

   task automatic write_digit(input logic [1:0] a, input logic [5:0] d);
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_valid = 1'b0;
   endtask

   function automatic int count_an(input int lo, input int hi, input logic [3:0] v);
      int c = 0;
      for (int k = lo; k <= hi; k++) if (an_s[k] == v) c++;
      return c;
   endfunction

   function automatic int count_lit(input int lo, input int hi);
      int c = 0;
      for (int k = lo; k <= hi; k++) if (an_s[k] != 4'hF) c++;
      return c;
   endfunction

   function automatic int count_ft(input int lo, input int hi);
      int c = 0;
      for (int k = lo; k <= hi; k++) if (ft_s[k]) c++;
      return c;
   endfunction

   initial begin
      int f0, f1, f2, f3;
      reset = 1'b1; enable = 1'b0; wr_valid = 1'b0; commit = 1'b0;
      wr_addr = 2'd0; wr_data = 6'd0; bright = 4'hF; blink_en = 4'h0;
      step(); step(); step();
      check_val("rst_an", an, 4'hF);
      check_val("rst_sseg", sseg, 7'h7F);
      check_val("rst_dp", dp, 1'b1);
      check_val("rst_tick", frame_tick, 1'b0);
      check_val("rst_ready", wr_ready, 1'b1);

      // Idle display: blank digits, frame period.
      reset = 1'b0; enable = 1'b1;
      wait_tick(cyc);
      check_val("first_tick_lat", cyc, 257);
      wait_tick(cyc);
      check_val("tick_period", cyc, 256);
      scan(1, 256);
      check_val("blank_lit_cnt", count_lit(1, 256), 0);
      check_val("blank_tick_k256", ft_s[256], 1'b1);

      // Load 0,1,A,F(dp), commit, then hold a write during the pending commit.
      write_digit(2'd0, 6'h00);
      write_digit(2'd1, 6'h01);
      write_digit(2'd2, 6'h0A);
      write_digit(2'd3, 6'h2F);
      commit = 1'b1;
      step();
      commit = 1'b0;
      check_val("pend_ready0", wr_ready, 1'b0);
      wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 6'h05;
      wait_tick(cyc);
      check_val("commit_wait", cyc, 251);
      check_val("ready_after_commit", wr_ready, 1'b1);
      scan(1, 1);
      wr_valid = 1'b0;
      scan(2, 256);
      check_val("d0_blank_k16", an_s[16], 4'hF);
      check_val("d0_an_k17", an_s[17], 4'hE);
      check_val("d0_seg_k17", sseg_s[17], 7'h40);
      check_val("d0_dp_k17", dp_s[17], 1'b1);
      check_val("d0_an_k64", an_s[64], 4'hE);
      check_val("d1_blank_k65", an_s[65], 4'hF);
      check_val("d1_an_k81", an_s[81], 4'hD);
      check_val("d1_seg_k81", sseg_s[81], 7'h79);
      check_val("d2_an_k145", an_s[145], 4'hB);
      check_val("d2_seg_k145", sseg_s[145], 7'h08);
      check_val("d3_an_k209", an_s[209], 4'h7);
      check_val("d3_seg_k209", sseg_s[209], 7'h0E);
      check_val("d3_dp_k209", dp_s[209], 1'b0);
      check_val("d3_an_k256", an_s[256], 4'h7);
      check_val("full_lit_cnt", count_lit(1, 256), 192);

      // Recommit (digit0 now 5) with brightness 3.
      bright = 4'd3;
      commit = 1'b1;
      step();
      commit = 1'b0;
      wait_tick(cyc);
      check_val("commit2_wait", cyc, 255);
      scan(1, 256);
      check_val("pwm_an_k17", an_s[17], 4'hE);
      check_val("pwm_seg_k17", sseg_s[17], 7'h12);
      check_val("pwm_an_k20", an_s[20], 4'hE);
      check_val("pwm_an_k21", an_s[21], 4'hF);
      check_val("pwm_an_k33", an_s[33], 4'hE);
      check_val("pwm_d1_k81", an_s[81], 4'hD);
      check_val("pwm_lit_cnt", count_lit(1, 256), 48);

      // Blink digit0 over four frames.
      bright = 4'hF; blink_en = 4'b0001;
      scan(1, 1024);
      f0 = count_an(1, 256, 4'hE);
      f1 = count_an(257, 512, 4'hE);
      f2 = count_an(513, 768, 4'hE);
      f3 = count_an(769, 1024, 4'hE);
      check_val("blink_d0_total", f0 + f1 + f2 + f3, 96);
      check_val("blink_f0_vs_f2", f0 + f2, 48);
      check_val("blink_f1_vs_f3", f1 + f3, 48);
      check_val("blink_f0_f1_pair", ((f0 == 48 || f0 == 0) && (f1 == 48 || f1 == 0)), 1'b1);
      check_val("blink_d1_total", count_an(1, 1024, 4'hD), 192);
      blink_en = 4'b0000;

      // Enable drop mid-slot with a commit while stopped.
      scan(1, 30);
      check_val("pre_drop_an", an_s[30], 4'hE);
      write_digit(2'd1, 6'h03);
      enable = 1'b0; commit = 1'b1;
      step();
      commit = 1'b0;
      check_val("drop_an", an, 4'hF);
      check_val("drop_ready", wr_ready, 1'b0);
      step();
      check_val("drop_commit_ready", wr_ready, 1'b1);
      check_val("drop_an2", an, 4'hF);
      enable = 1'b1;
      step();
      scan(1, 256);
      check_val("reen_k16", an_s[16], 4'hF);
      check_val("reen_an_k17", an_s[17], 4'hE);
      check_val("reen_seg_k17", sseg_s[17], 7'h12);
      check_val("reen_d1_an", an_s[81], 4'hD);
      check_val("reen_d1_seg", sseg_s[81], 7'h30);
      check_val("reen_tick_k256", ft_s[256], 1'b1);
      check_val("reen_tick_cnt", count_ft(1, 256), 1);

      // Reset mid-frame with a commit pending.
      scan(1, 40);
      write_digit(2'd2, 6'h07);
      commit = 1'b1;
      step();
      commit = 1'b0;
      check_val("prereset_ready", wr_ready, 1'b0);
      reset = 1'b1;
      step();
      check_val("mid_rst_an", an, 4'hF);
      check_val("mid_rst_sseg", sseg, 7'h7F);
      check_val("mid_rst_dp", dp, 1'b1);
      check_val("mid_rst_ready", wr_ready, 1'b1);
      reset = 1'b0;
      scan(1, 300);
      check_val("post_rst_lit_cnt", count_lit(1, 300), 0);
      check_val("post_rst_tick_k257", ft_s[257], 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
